// File: rtl/bgd_mul_arb_pkg.sv
// rtl/bgd_mul_arb_pkg.sv - shared constants and types for the BGD multiplier arbiter
// Purpose: default operand width, requester-id width helper and the tag that
//          travels alongside each operation through the multiplier pipeline.
// Ports:   none (package).
package bgd_mul_arb_pkg;

  localparam int DATA_W_DEF = 15;

  // Widest requester id ever needed (up to 8 requesters).
  localparam int MAX_ID_W = 3;

  function automatic int id_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // One entry of the tag pipeline: valid flag plus owning requester.
  typedef struct packed {
    logic                v;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/bgd_rr_arbiter.sv
// rtl/bgd_rr_arbiter.sv - round-robin grant with registered priority pointer
// Purpose: picks the first valid requester at or after rr_ptr (wrapping) and
//          advances rr_ptr past the winner on enabled grant cycles.
// Ports:   clk, reset      - clock, async active-high reset
//          en              - allow rr_ptr to advance this cycle
//          req_valid       - per-requester request
//          grant           - one-hot grant (combinational)
//          grant_valid     - some requester was granted
//          grant_id        - binary index of the granted requester
module bgd_rr_arbiter
  import bgd_mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W:0]   scan_sum;
  logic [ID_W-1:0] scan_idx;

  // Scan N_REQ positions starting at rr_ptr; the extra sum bit lets the
  // modulo be a single conditional subtract for non-power-of-two N_REQ.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    scan_sum    = '0;
    scan_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (scan_sum >= (ID_W+1)'(N_REQ)) begin
        scan_sum = scan_sum - (ID_W+1)'(N_REQ);
      end
      scan_idx = scan_sum[ID_W-1:0];
      if (!grant_valid && req_valid[scan_idx]) begin
        grant_valid = 1'b1;
        grant_id    = scan_idx;
      end
    end
  end

  assign grant = grant_valid ? (N_REQ'(1) << grant_id) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (en && grant_valid) begin
      rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/bgd_mul_arbiter.sv
// rtl/bgd_mul_arbiter.sv - shares one pipelined signed multiplier among N_REQ requesters
// Purpose: round-robin issue of operand pairs into an external MUL_LAT-deep
//          multiplier, tag tracking of ownership, and per-requester result
//          return with pipeline-wide stall through mul_ce.
// Ports:   clk, reset            - clock, async active-high reset
//          req_valid/ready/a/b   - per-requester operand handshake (packed a/b)
//          res_valid/ready, res_p- per-requester result handshake, shared product
//          mul_ce/din0/din1/dout - connection to the external multiplier
//          busy                  - at least one operation in flight
module bgd_mul_arbiter
  import bgd_mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        res_valid,
  input  logic [N_REQ-1:0]        res_ready,
  output logic [DATA_W-1:0]       res_p,
  output logic                    mul_ce,
  output logic [DATA_W-1:0]       mul_din0,
  output logic [DATA_W-1:0]       mul_din1,
  input  logic [DATA_W-1:0]       mul_dout,
  output logic                    busy
);

  localparam int ID_W = id_w(N_REQ);

  tag_t             tags [MUL_LAT];
  tag_t             out_tag;
  logic             stall;
  logic             issue;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;

  bgd_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .clk         (clk),
    .reset       (reset),
    .en          (mul_ce),
    .req_valid   (req_valid),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign out_tag = tags[MUL_LAT-1];

  always_comb begin
    res_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (out_tag.v && out_tag.id == MAX_ID_W'(i)) begin
        res_valid[i] = 1'b1;
      end
    end
  end

  // Only a presented, unaccepted result freezes the pipeline; a bubble at
  // the output never does.
  assign stall  = |(res_valid & ~res_ready);
  assign mul_ce = ~stall;
  assign res_p  = mul_dout;

  // Reset also masks the combinational grant so outputs are quiet during reset.
  assign issue     = grant_valid & mul_ce & ~reset;
  assign req_ready = issue ? grant : '0;

  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (issue) begin
      mul_din0 = req_a[int'(grant_id)*DATA_W +: DATA_W];
      mul_din1 = req_b[int'(grant_id)*DATA_W +: DATA_W];
    end
  end

  // Tags shift in lockstep with the multiplier's own ce-enabled registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < MUL_LAT; s++) begin
        tags[s] <= '0;
      end
    end else if (mul_ce) begin
      tags[0].v  <= issue;
      tags[0].id <= issue ? MAX_ID_W'(grant_id) : '0;
      for (int s = 1; s < MUL_LAT; s++) begin
        tags[s] <= tags[s-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < MUL_LAT; s++) begin
      busy = busy | tags[s].v;
    end
  end

endmodule

// File: tb/tb_bgd_mul_arbiter.sv
// tb/tb_bgd_mul_arbiter.sv - self-checking bench for bgd_mul_arbiter
module tb_bgd_mul_arbiter;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 15;
  localparam int MUL_LAT = 3;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ-1:0]        res_valid;
  logic [N_REQ-1:0]        res_ready;
  logic [DATA_W-1:0]       res_p;
  logic                    mul_ce;
  logic [DATA_W-1:0]       mul_din0;
  logic [DATA_W-1:0]       mul_din1;
  logic [DATA_W-1:0]       mul_dout;
  logic                    busy;

  logic signed [DATA_W-1:0] a_in [N_REQ];
  logic signed [DATA_W-1:0] b_in [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_pack
    assign req_a[g*DATA_W +: DATA_W] = a_in[g];
    assign req_b[g*DATA_W +: DATA_W] = b_in[g];
  end

  always #5 clk = ~clk;

  bgd_mul_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_p(res_p), .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout), .busy(busy)
  );

  // External multiplier: MUL_LAT ce-enabled stages, no reset.
  logic [DATA_W-1:0]          mpipe [MUL_LAT];
  logic signed [2*DATA_W-1:0] mfull;
  assign mfull    = $signed(mul_din0) * $signed(mul_din1);
  assign mul_dout = mpipe[MUL_LAT-1];
  always @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= mfull[DATA_W-1:0];
      for (int s = 1; s < MUL_LAT; s++) mpipe[s] <= mpipe[s-1];
    end
  end

  // Reference: wrapped signed product from plain integer arithmetic.
  function automatic int prod_wrap(input int a, input int b);
    int p;
    p = (a * b) & ((1 << DATA_W) - 1);
    if (p >= (1 << (DATA_W - 1))) p = p - (1 << DATA_W);
    return p;
  endfunction

  typedef struct {
    int id;
    int p;
    int cnt;   // number of advancing edges seen since acceptance
  } op_t;

  op_t q[$];
  int  rr = 0;
  int  last_grant = -1;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  ce_low_cnt = 0;
  int  busy_cnt = 0;
  int  acc_log[$];
  int  acc_cyc[$];
  int  ret_id[$];
  int  ret_p[$];
  int  ret_cyc[$];

  bit                m_front;
  bit                m_stall;
  int                m_gid;
  logic [N_REQ-1:0]  m_ready;
  logic [N_REQ-1:0]  m_rv;
  logic [DATA_W-1:0] m_a;
  logic [DATA_W-1:0] m_b;

  // Per-cycle model comparison, sampled on the falling edge; the model then
  // advances as if the coming rising edge had happened.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      checks++;
      if (req_ready !== '0 || res_valid !== '0 || busy !== 1'b0 || mul_ce !== 1'b1 ||
          mul_din0 !== '0 || mul_din1 !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got ready=%b rv=%b busy=%b ce=%b din0=%h din1=%h",
                 cyc, req_ready, res_valid, busy, mul_ce, mul_din0, mul_din1);
      end
      q.delete();
      rr = 0;
      last_grant = -1;
    end else begin
      m_front = (q.size() > 0) && (q[0].cnt == MUL_LAT);
      m_stall = m_front && !res_ready[q[0].id];
      m_gid = -1;
      if (!m_stall) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (m_gid < 0 && req_valid[(rr + k) % N_REQ]) m_gid = (rr + k) % N_REQ;
        end
      end
      m_ready = (m_gid >= 0) ? (N_REQ'(1) << m_gid) : '0;
      m_rv    = m_front ? (N_REQ'(1) << q[0].id) : '0;
      m_a     = (m_gid >= 0) ? a_in[m_gid] : '0;
      m_b     = (m_gid >= 0) ? b_in[m_gid] : '0;

      checks++;
      if (req_ready !== m_ready) begin
        errors++;
        $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, m_ready);
      end
      checks++;
      if (mul_ce !== (m_stall ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL mul_ce cyc=%0d got=%b exp=%b", cyc, mul_ce, !m_stall);
      end
      checks++;
      if (res_valid !== m_rv) begin
        errors++;
        $display("FAIL res_valid cyc=%0d got=%b exp=%b", cyc, res_valid, m_rv);
      end
      checks++;
      if (busy !== (q.size() > 0)) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() > 0);
      end
      checks++;
      if (mul_din0 !== m_a || mul_din1 !== m_b) begin
        errors++;
        $display("FAIL mul_din cyc=%0d got=%h/%h exp=%h/%h", cyc, mul_din0, mul_din1, m_a, m_b);
      end
      if (m_front) begin
        checks++;
        if (res_p !== DATA_W'(q[0].p)) begin
          errors++;
          $display("FAIL res_p cyc=%0d got=%0d exp=%0d", cyc, $signed(res_p), q[0].p);
        end
      end

      if (mul_ce === 1'b0) ce_low_cnt++;
      if (busy === 1'b1) busy_cnt++;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] === 1'b1) begin
          acc_log.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end

      last_grant = m_gid;
      if (!m_stall) begin
        if (m_front) begin
          ret_id.push_back(q[0].id);
          ret_p.push_back(int'($signed(res_p)));
          ret_cyc.push_back(cyc);
          void'(q.pop_front());
        end
        foreach (q[j]) q[j].cnt++;
        if (m_gid >= 0) begin
          q.push_back('{m_gid, prod_wrap(int'(a_in[m_gid]), int'(b_in[m_gid])), 1});
          rr = (m_gid + 1) % N_REQ;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete();
    ret_id.delete(); ret_p.delete(); ret_cyc.delete();
    ce_low_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    res_ready = '1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Raise the requesters in mask and drop each one as soon as it is accepted.
  task automatic issue_set(input logic [N_REQ-1:0] mask);
    bit done;
    done = 1'b0;
    req_valid = req_valid | mask;
    for (int n = 0; n < 50 && !done; n++) begin
      tick();
      if (last_grant >= 0) req_valid[last_grant] = 1'b0;
      if ((req_valid & mask) == '0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_timeout got_pending=%b exp=0", req_valid & mask);
      req_valid = '0;
    end
  endtask

  task automatic issue_one(input int i, input int a, input int b);
    a_in[i] = DATA_W'(a);
    b_in[i] = DATA_W'(b);
    issue_set(N_REQ'(1) << i);
  endtask

  task automatic wait_idle(input int limit);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < limit && !idle; n++) begin
      tick();
      if (q.size() == 0) idle = 1'b1;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL drain_timeout got_inflight=%0d exp=0", q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    reset = 1'b1;
    req_valid = '1;
    #1;
    checks++;
    if (req_ready !== '0 || res_valid !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async_hs got ready=%b rv=%b busy=%b exp=0/0/0", req_ready, res_valid, busy);
    end
    checks++;
    if (mul_ce !== 1'b1 || mul_din0 !== '0 || mul_din1 !== '0) begin
      errors++;
      $display("FAIL reset_async_mul got ce=%b din0=%h din1=%h exp=1/0/0", mul_ce, mul_din0, mul_din1);
    end
    tick();
    tick();
    req_valid = '0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    clear_logs();
    issue_one(2, 3, -5);
    wait_idle(20);
    checks++;
    if (acc_log.size() != 1 || acc_log[0] != 2) begin
      errors++;
      $display("FAIL single_accept got n=%0d exp n=1 id=2", acc_log.size());
    end
    checks++;
    if (ret_p.size() != 1 || ret_p[0] != -15 || ret_id[0] != 2) begin
      errors++;
      $display("FAIL single_result got n=%0d exp n=1 p=-15 id=2", ret_p.size());
    end
    checks++;
    if (ret_cyc.size() != 1 || acc_cyc.size() != 1 || ret_cyc[0] - acc_cyc[0] != MUL_LAT) begin
      errors++;
      $display("FAIL single_latency got nret=%0d nacc=%0d exp latency=%0d", ret_cyc.size(), acc_cyc.size(), MUL_LAT);
    end
    checks++;
    if (busy_cnt != MUL_LAT) begin
      errors++;
      $display("FAIL single_busy got=%0d exp=%0d", busy_cnt, MUL_LAT);
    end
  endtask

  task automatic test_round_robin();
    int exp_id[5];
    exp_id = '{0, 1, 2, 3, 0};
    do_reset();
    clear_logs();
    for (int i = 0; i < N_REQ; i++) begin
      a_in[i] = DATA_W'(i + 1);
      b_in[i] = DATA_W'(10);
    end
    req_valid = '1;
    for (int n = 0; n < 20 && acc_log.size() < 5; n++) tick();
    req_valid = '0;
    wait_idle(20);
    checks++;
    if (acc_log.size() != 5) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=5", acc_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (acc_log[k] != exp_id[k]) begin
          errors++;
          $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, acc_log[k], exp_id[k]);
        end
      end
    end
    checks++;
    if (ret_p.size() != 5) begin
      errors++;
      $display("FAIL rr_results got=%0d exp=5", ret_p.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ret_p[k] != 10 * (k + 1) || ret_id[k] != k || ret_cyc[k] - ret_cyc[0] != k) begin
          errors++;
          $display("FAIL rr_result k=%0d got p=%0d id=%0d dcyc=%0d exp p=%0d id=%0d dcyc=%0d",
                   k, ret_p[k], ret_id[k], ret_cyc[k] - ret_cyc[0], 10 * (k + 1), k, k);
        end
      end
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    issue_one(1, 200, 200);
    issue_one(1, -16384, 2);
    wait_idle(20);
    checks++;
    if (ret_p.size() != 2 || ret_p[0] != 7232 || ret_p[1] != 0) begin
      errors++;
      $display("FAIL wrap got n=%0d exp p=7232,0", ret_p.size());
    end
  endtask

  task automatic test_backpressure();
    int sent, hold;
    bit seen;
    sent = 0; hold = 0; seen = 1'b0;
    clear_logs();
    res_ready = '1;
    a_in[0] = DATA_W'(1);
    b_in[0] = DATA_W'(7);
    req_valid[0] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (last_grant == 0) begin
        sent++;
        if (sent < 6) a_in[0] = DATA_W'(sent + 1);
        else req_valid[0] = 1'b0;
      end
      if (!seen && res_valid[0] === 1'b1) begin
        seen = 1'b1;
        hold = 5;
      end
      if (hold > 0) begin
        res_ready[0] = 1'b0;
        hold--;
      end else begin
        res_ready[0] = 1'b1;
      end
      if (sent == 6 && q.size() == 0) break;
    end
    req_valid = '0;
    res_ready = '1;
    wait_idle(20);
    checks++;
    if (ce_low_cnt != 5) begin
      errors++;
      $display("FAIL bp_stall_cycles got=%0d exp=5", ce_low_cnt);
    end
    checks++;
    if (acc_log.size() != 6 || ret_p.size() != 6) begin
      errors++;
      $display("FAIL bp_count got acc=%0d ret=%0d exp=6/6", acc_log.size(), ret_p.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (ret_p[k] != 7 * (k + 1)) begin
          errors++;
          $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, ret_p[k], 7 * (k + 1));
        end
      end
    end
  endtask

  task automatic test_bubbles();
    clear_logs();
    b_in[1] = DATA_W'(3);
    for (int k = 0; k < 8; k++) begin
      req_valid[1] = (k % 2 == 0);
      a_in[1] = DATA_W'(k + 1);
      tick();
    end
    req_valid = '0;
    wait_idle(20);
    checks++;
    if (ce_low_cnt != 0) begin
      errors++;
      $display("FAIL bubble_ce got_low=%0d exp=0", ce_low_cnt);
    end
    checks++;
    if (acc_log.size() != 4 || ret_p.size() != 4) begin
      errors++;
      $display("FAIL bubble_count got acc=%0d ret=%0d exp=4/4", acc_log.size(), ret_p.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ret_cyc[k] - acc_cyc[0] != MUL_LAT + 2 * k || ret_id[k] != 1 || ret_p[k] != 3 * (2 * k + 1)) begin
          errors++;
          $display("FAIL bubble_ret k=%0d got dcyc=%0d id=%0d p=%0d exp dcyc=%0d id=1 p=%0d",
                   k, ret_cyc[k] - acc_cyc[0], ret_id[k], ret_p[k], MUL_LAT + 2 * k, 3 * (2 * k + 1));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      a_in[i] = DATA_W'(i + 2);
      b_in[i] = DATA_W'(11);
    end
    issue_set(4'b0111);
    reset = 1'b1;
    #1;
    checks++;
    if (res_valid !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL midflight_reset got rv=%b busy=%b ready=%b exp=0/0/0", res_valid, busy, req_ready);
    end
    tick();
    tick();
    reset = 1'b0;
    clear_logs();
    a_in[1] = DATA_W'(-7);
    b_in[1] = DATA_W'(9);
    a_in[3] = DATA_W'(100);
    b_in[3] = DATA_W'(-3);
    issue_set(4'b1010);
    wait_idle(20);
    checks++;
    if (acc_log.size() != 2 || acc_log[0] != 1 || acc_log[1] != 3) begin
      errors++;
      $display("FAIL midflight_rr got n=%0d exp order 1,3", acc_log.size());
    end
    checks++;
    if (ret_p.size() != 2 || ret_p[0] != -63 || ret_p[1] != -300 || ret_id[1] != 3) begin
      errors++;
      $display("FAIL midflight_result got n=%0d exp -63,-300", ret_p.size());
    end
  endtask

  task automatic test_random();
    clear_logs();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!(req_valid[i] && last_grant != i)) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          a_in[i] = DATA_W'($urandom);
          b_in[i] = DATA_W'($urandom);
        end
      end
      for (int i = 0; i < N_REQ; i++) res_ready[i] = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    res_ready = '1;
    wait_idle(40);
    checks++;
    if (acc_log.size() != ret_p.size() || acc_log.size() == 0) begin
      errors++;
      $display("FAIL random_conservation got acc=%0d ret=%0d exp equal nonzero", acc_log.size(), ret_p.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0;
    res_ready = '1;
    for (int i = 0; i < N_REQ; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_bubbles();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
